// File: rtl/dmem_ls_if.sv
// dmem_ls_if: request/response handshake bundle for the data memory.
// The master issues sized loads/stores; the slave answers one per request.
interface dmem_ls_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ls.sv
// dmem_ls: byte-addressable RV32I data memory with sized loads/stores
// and a one-deep registered response behind a valid/ready handshake.
module dmem_ls #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input logic      clk,
    input logic      rst_n,
    dmem_ls_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH] = '{default: '0};

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [2:0]    f3;
    logic          is_b, is_h, is_w;
    logic          oor, bad, err, accept, wr_en;
    logic [3:0]    be;
    logic [31:0]   wdata_al, word, ld;
    logic [7:0]    b;
    logic [15:0]   h;

    assign idx  = bus.req_addr[AW+1:2];
    assign lane = bus.req_addr[1:0];
    assign f3   = bus.req_funct3;
    assign oor  = |bus.req_addr[31:AW+2];
    assign word = mem_q[idx];

    assign is_b = (f3 == 3'b000) || (f3 == 3'b100);
    assign is_h = (f3 == 3'b001) || (f3 == 3'b101);
    assign is_w = (f3 == 3'b010);

    // Lane enables, lane-replicated store data and extended load data
    always_comb begin
        be       = '0;
        wdata_al = '0;
        ld       = '0;
        b        = '0;
        h        = '0;
        bad      = 1'b0;
        unique case (1'b1)
            is_b: begin
                be       = 4'b0001 << lane;
                wdata_al = {4{bus.req_wdata[7:0]}};
                b        = word[{lane, 3'b000} +: 8];
                ld       = {{24{b[7] & ~f3[2]}}, b};
            end
            is_h: begin
                bad      = lane[0];
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{bus.req_wdata[15:0]}};
                h        = lane[1] ? word[31:16] : word[15:0];
                ld       = {{16{h[15] & ~f3[2]}}, h};
            end
            is_w: begin
                bad      = |lane;
                be       = 4'b1111;
                wdata_al = bus.req_wdata;
                ld       = word;
            end
            default: bad = 1'b1;
        endcase
    end

    assign err    = oor || bad || (bus.req_we && f3[2]);
    assign accept = bus.req_valid && bus.req_ready;
    assign wr_en  = accept && bus.req_we && !err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem_q[idx][8*k +: 8] <= wdata_al[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            state_d = FULL;
            err_d   = err;
            rdata_d = (err || bus.req_we) ? 32'd0 : ld;
        end else if (bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == EMPTY) || bus.rsp_ready;
    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ls.sv
// tb_dmem_ls: directed and random load/store traffic checked against
// a byte-array reference model of the data memory.
module tb_dmem_ls;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;

    dmem_ls_if bus ();

    dmem_ls #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mm [DEPTH*4];
    logic        m_full;
    logic [31:0] m_rdata;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic void model_acc(input logic we, input logic [2:0] f3,
                                      input logic [31:0] a,
                                      input logic [31:0] wd,
                                      output logic e,
                                      output logic [31:0] rd);
        int          n;
        logic [31:0] v;
        n  = 1 << f3[1:0];
        e  = (a >= 32'(DEPTH*4)) || (f3 == 3'd3) || (f3 >= 3'd6) ||
             (we && f3 >= 3'd4) || (n == 2 && a[0]) ||
             (n == 4 && a[1:0] != 2'd0);
        rd = '0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) mm[a+32'(i)] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++)
                    v = v | (32'(mm[a+32'(i)]) << (8*i));
                if (f3 < 3'd4 && n < 4 && v[8*n-1])
                    v = v | (32'hFFFF_FFFF << (8*n));
                rd = v;
            end
        end
    endfunction

    task automatic step(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic rr);
        logic        acc;
        logic        e;
        logic [31:0] rd;
        @(negedge clk);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.rsp_ready  = rr;
        #1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
        chk("req_ready", 32'(bus.req_ready), 32'(!m_full || rr));
        if (m_full) begin
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
            chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
        end
        acc = v && (!m_full || rr);
        if (acc) begin
            model_acc(we, f3, a, wd, e, rd);
            m_full  = 1'b1;
            m_rdata = rd;
            m_err   = e;
        end else if (rr) begin
            m_full = 1'b0;
        end
    endtask

    task automatic peek(input string tag, input logic [31:0] exp_rd,
                        input logic exp_err);
        @(posedge clk);
        #1;
        chk(tag, bus.rsp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;

        for (int i = 0; i < DEPTH*4; i++) mm[i] = '0;
        m_full  = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step(1, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1);
        peek("sw_rsp", 32'd0, 1'b0);
        step(1, 0, 3'd2, 32'h10, 32'h0, 1);
        peek("lw_10", 32'hDEAD_BEEF, 1'b0);
        step(1, 0, 3'd0, 32'h13, 32'h0, 1);
        peek("lb_13", 32'hFFFF_FFDE, 1'b0);
        step(1, 0, 3'd4, 32'h13, 32'h0, 1);
        peek("lbu_13", 32'h0000_00DE, 1'b0);
        step(1, 0, 3'd1, 32'h12, 32'h0, 1);
        peek("lh_12", 32'hFFFF_DEAD, 1'b0);
        step(1, 0, 3'd5, 32'h10, 32'h0, 1);
        peek("lhu_10", 32'h0000_BEEF, 1'b0);
        step(1, 1, 3'd0, 32'h11, 32'hAAAA_AA55, 1);
        step(1, 1, 3'd1, 32'h12, 32'hBBBB_1234, 1);
        step(1, 0, 3'd2, 32'h10, 32'h0, 1);
        peek("lw_mix", 32'h1234_55EF, 1'b0);

        step(1, 0, 3'd1, 32'h11, 32'h0, 1);
        peek("lh_mis", 32'd0, 1'b1);
        step(1, 1, 3'd2, 32'h12, 32'hFFFF_FFFF, 1);
        peek("sw_mis", 32'd0, 1'b1);
        step(1, 0, 3'd2, 32'h10, 32'h0, 1);
        peek("lw_chk1", 32'h1234_55EF, 1'b0);
        step(1, 0, 3'd2, 32'(DEPTH*4), 32'h0, 1);
        peek("lw_oor", 32'd0, 1'b1);
        step(1, 0, 3'd3, 32'h10, 32'h0, 1);
        peek("f3_011", 32'd0, 1'b1);
        step(1, 1, 3'd4, 32'h10, 32'h0, 1);
        peek("sbu_ill", 32'd0, 1'b1);
        step(1, 0, 3'd2, 32'h10, 32'h0, 1);
        peek("lw_chk2", 32'h1234_55EF, 1'b0);

        step(1, 0, 3'd2, 32'h10, 32'h0, 1);
        repeat (3) step(1, 0, 3'd0, 32'h13, 32'h0, 0);
        step(1, 0, 3'd0, 32'h13, 32'h0, 1);
        peek("bp_lb", 32'h0000_0012, 1'b0);

        step(1, 0, 3'd2, 32'h10, 32'h0, 0);
        step(0, 0, 3'd0, 32'h0, 32'h0, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("mrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mrst_err", 32'(bus.rsp_err), 32'd0);
        chk("mrst_rdata", bus.rsp_rdata, 32'd0);
        m_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 3'd2, 32'h10, 32'h0, 1);
        peek("post_rst", 32'h1234_55EF, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 99);
            if (r < 5)       a = $urandom;
            else if (r < 15) a = 32'($urandom_range(0, DEPTH*4-1));
            else             a = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
                 f3, a, $urandom, $urandom_range(0, 9) < 7);
        end
        step(0, 0, 3'd0, 32'h0, 32'h0, 1);
        step(0, 0, 3'd0, 32'h0, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/dmem_ls.md
# dmem_ls

Byte-addressable, parametrised data memory for the synapse32 core's memory stage. It replaces the word-only, combinational-read data memory. It adds RISC-V RV32I load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW), little-endian byte lanes, a registered single-cycle read, and a valid/ready request/response handshake with back-pressure. It also flags misaligned, out-of-range and illegal-size accesses instead of silently aliasing addresses.

## Interface
- DEPTH, 1024: memory size in 32-bit words; power of two, 2..65536.
- AW, $clog2(DEPTH): word-index width, derived; do not override.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or half is used for SB/SH.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  the request was rejected (see Operation).

## Operation
- Storage is DEPTH x 32 bits. Word index is req_addr[AW+1:2]. Byte lane k holds bits [8k+7:8k], and lane k is selected by addr[1:0] = k.
- Memory contents are initialised to zero at simulation start. rst_n does not clear memory.
- req_ready = !rsp_valid || rsp_ready (one-deep response register).
- A request is accepted when req_valid && req_ready.
- Every accepted request produces exactly one response, including stores and errors.
- An error is raised when any of these holds:
  - req_addr[31:AW+2] != 0 (out of range);
  - H/HU with addr[0] = 1, or W with addr[1:0] != 0 (misaligned);
  - funct3 is 011, 110 or 111;
  - a store uses funct3 100 or 101.
- On error: no memory write, rsp_err = 1, rsp_rdata = 0.
- Store writes:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Load results:
  - LB/LBU select the byte at lane addr[1:0].
  - LH/LHU select the half at lanes addr[1]*2 and addr[1]*2+1.
  - LW returns the whole word.
  - B and H are sign-extended; BU and HU are zero-extended.
- There is no internal state machine beyond the response register: states are EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready together with an accept (back-to-back).
  - FULL with no rsp_ready holds all response outputs stable.

## Timing
- Reset values (asynchronous, immediate): rsp_valid = 0, rsp_err = 0, rsp_rdata = 0. req_ready is therefore 1.
- Latency is 1 cycle. A request accepted at rising edge N has its write (if any) committed at edge N. Its response is registered at edge N and visible from N until consumed.
- Throughput is one request per cycle while rsp_ready = 1.
- Read-after-write: a load accepted at edge N+1 to a location stored at edge N returns the new data.
- Load and store data are captured at acceptance. A later stall never changes rsp_rdata.
- Stall: with rsp_valid = 1 and rsp_ready = 0, req_ready = 0. No request is accepted and memory is untouched.
- Reset asserted mid-operation:
  - a pending response is dropped (rsp_valid -> 0);
  - a store accepted on the same edge that reset asserts is not guaranteed;
  - a store committed on an earlier edge persists.
- Inputs are ignored when req_valid = 0. req_wdata is ignored for loads.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10 with rsp_ready = 1 -> store response has rsp_err = 0, rdata = 0. The load response on the next cycle has rdata = 0xDEADBEEF.
- After that word is written: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB 0x55 @0x11, then SH 0x1234 @0x12, then LW @0x10 -> 0x12345 5EF, i.e. 0x123455EF; the other lanes are unchanged.
- Error cases, each followed by LW @0x10 returning 0x123455EF (no write occurred):
  - LH @0x11 -> rsp_err = 1, rdata = 0;
  - SW @0x12 -> rsp_err = 1;
  - LW @(DEPTH*4) -> rsp_err = 1;
  - funct3 = 011 -> rsp_err = 1.
- Back-pressure: hold rsp_ready = 0 after a load accept, for 3 cycles -> req_ready = 0 and rsp_rdata stable. Then raise rsp_ready with req_valid held -> the next request is accepted on that same edge and the response follows 1 cycle later.
- Assert rst_n low while rsp_valid = 1 -> rsp_valid, rsp_err and rsp_rdata go to 0 immediately. After release, LW of a previously stored word returns its value.
